// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word read per instruction, holds the
// returned word with its address until downstream accepts it, then computes
// the next fetch address (sequential or branch target).
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [6:0]        op,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_offset
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] target_raw;
  logic [ADDR_W-1:0] target;
  logic              load_instr;
  logic              handshake;

  // Next-state decode and control strobes; request/valid derive from state so
  // that an asynchronous reset drops them immediately.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_instr  = 1'b0;
    handshake   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_instr = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          handshake = 1'b1;
          state_nxt = enable ? FETCH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next fetch address: branch target or sequential, word aligned, wraps
  // naturally modulo 2^ADDR_W.
  always_comb begin
    target_raw = pc_src ? (pc + branch_offset) : (pc + ADDR_W'(4));
    target     = {target_raw[ADDR_W-1:2], 2'b00};
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Datapath registers: captured instruction/address and next fetch address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      pc       <= RESET_PC;
      instr    <= '0;
    end else begin
      if (load_instr) begin
        instr <= imem_rdata;
        pc    <= fetch_pc;
      end
      if (handshake) fetch_pc <= target;
    end
  end

  assign imem_addr = fetch_pc;
  assign op        = instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable, imem_ready, instr_ready, pc_src;
  logic [31:0] imem_rdata, branch_offset;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc;
  logic [6:0]  op;

  // Second instance with a reset address at the top of memory.
  logic        w_enable, w_imem_ready, w_instr_ready, w_pc_src;
  logic [31:0] w_imem_rdata, w_branch_offset;
  logic        w_imem_req, w_instr_valid;
  logic [31:0] w_imem_addr, w_instr, w_pc;
  logic [6:0]  w_op;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr(instr), .op(op), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .pc_src(pc_src),
    .branch_offset(branch_offset)
  );

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset_n(reset_n), .enable(w_enable),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(w_imem_ready),
    .imem_rdata(w_imem_rdata), .instr(w_instr), .op(w_op),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .pc(w_pc),
    .pc_src(w_pc_src), .branch_offset(w_branch_offset)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: a fetch is outstanding, an instruction is held,
  // or the unit is idle.
  bit          m_fetching, m_holding;
  logic [31:0] m_fetch_pc, m_pc, m_instr;

  task automatic model_reset();
    m_fetching = 0;
    m_holding  = 0;
    m_fetch_pc = 32'h0;
    m_pc       = 32'h0;
    m_instr    = 32'h0;
  endtask

  task automatic model_clock();
    logic [31:0] nxt;
    if (m_holding) begin
      if (instr_ready) begin
        nxt        = pc_src ? m_pc + branch_offset : m_pc + 32'd4;
        m_fetch_pc = nxt & 32'hFFFF_FFFC;
        m_holding  = 0;
        m_fetching = enable;
      end
    end else if (m_fetching) begin
      if (imem_ready) begin
        m_instr    = imem_rdata;
        m_pc       = m_fetch_pc;
        m_fetching = 0;
        m_holding  = 1;
      end
    end else if (enable) begin
      m_fetching = 1;
    end
  endtask

  task automatic check_all();
    check_eq("imem_req", 64'(imem_req), 64'(m_fetching));
    check_eq("imem_addr", 64'(imem_addr), 64'(m_fetch_pc));
    check_eq("instr_valid", 64'(instr_valid), 64'(m_holding));
    check_eq("instr", 64'(instr), 64'(m_instr));
    check_eq("op", 64'(op), 64'(m_instr[6:0]));
    check_eq("pc", 64'(pc), 64'(m_pc));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_clock();
    @(negedge clk);
    check_all();
  endtask

  // Assert reset off-edge and verify the outputs drop without a clock.
  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_req_now", 64'(imem_req), 64'd0);
    check_eq("rst_valid_now", 64'(instr_valid), 64'd0);
    check_eq("rst_op_now", 64'(op), 64'd0);
    model_reset();
    check_all();
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 0; imem_ready = 0; instr_ready = 0; pc_src = 0;
    imem_rdata = 32'h0; branch_offset = 32'h0;
    w_enable = 1; w_imem_ready = 1; w_instr_ready = 1; w_pc_src = 0;
    w_imem_rdata = 32'h0000_0013; w_branch_offset = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    check_eq("wrap_rst_addr", 64'(w_imem_addr), 64'hFFFF_FFFC);
    check_eq("wrap_rst_req", 64'(w_imem_req), 64'd0);

    // Zero-wait streaming of NOPs.
    enable = 1; imem_ready = 1; instr_ready = 1; imem_rdata = 32'h0000_0013;
    reset_n = 1'b1;
    step();
    check_eq("seq_addr0", 64'(imem_addr), 64'h0);
    check_eq("seq_req0", 64'(imem_req), 64'd1);
    check_eq("wrap_addr_top", 64'(w_imem_addr), 64'hFFFF_FFFC);
    step();
    check_eq("seq_op0", 64'(op), 64'h13);
    check_eq("wrap_pc_top", 64'(w_pc), 64'hFFFF_FFFC);
    step();
    check_eq("seq_addr4", 64'(imem_addr), 64'h4);
    check_eq("wrap_addr_zero", 64'(w_imem_addr), 64'h0);
    check_eq("wrap_req", 64'(w_imem_req), 64'd1);
    step();
    check_eq("seq_op1", 64'(op), 64'h13);
    step();
    check_eq("seq_addr8", 64'(imem_addr), 64'h8);

    // Memory wait states at 0x8.
    imem_ready = 0;
    repeat (3) begin
      step();
      check_eq("wait_req", 64'(imem_req), 64'd1);
      check_eq("wait_addr", 64'(imem_addr), 64'h8);
    end
    imem_ready = 1;
    step();
    check_eq("wait_valid", 64'(instr_valid), 64'd1);
    check_eq("wait_pc", 64'(pc), 64'h8);

    // Advance to HOLD at 0x10, then backpressure and a backward branch.
    repeat (4) step();
    check_eq("bp_pc", 64'(pc), 64'h10);
    instr_ready = 0; imem_rdata = 32'hDEAD_BEEF;
    repeat (5) begin
      step();
      check_eq("bp_instr", 64'(instr), 64'h13);
      check_eq("bp_valid", 64'(instr_valid), 64'd1);
    end
    instr_ready = 1; pc_src = 1; branch_offset = 32'hFFFF_FFF8;
    step();
    check_eq("br_addr", 64'(imem_addr), 64'h8);
    pc_src = 0; branch_offset = 32'h0;

    // Enable dropped during a fetch.
    enable = 0;
    step();
    check_eq("en_hold", 64'(instr_valid), 64'd1);
    repeat (4) begin
      step();
      check_eq("en_idle_req", 64'(imem_req), 64'd0);
    end
    enable = 1;
    step();
    check_eq("en_resume_req", 64'(imem_req), 64'd1);

    // Reset while holding.
    step();
    check_eq("rst_pre_valid", 64'(instr_valid), 64'd1);
    async_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_eq("rst_refetch", 64'(imem_addr), 64'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      enable        = ($urandom_range(0, 9) < 8);
      imem_ready    = $urandom_range(0, 1) == 1;
      instr_ready   = $urandom_range(0, 1) == 1;
      pc_src        = ($urandom_range(0, 9) < 3);
      imem_rdata    = $urandom;
      branch_offset = ($urandom_range(0, 3) == 0) ? $urandom
                      : 32'($signed($urandom_range(0, 256)) - 128);
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        @(negedge clk);
        reset_n = 1'b1;
        check_all();
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
